// File: rtl/tune_sequencer.sv
// Note-table tune player: walks programmed (period, duration) entries and drives the tone generator.
// Optional build macro TUNE_SEQUENCER_LOOP_EN adds a `loop` input that restarts playback after the last entry.
module tune_sequencer #(
    parameter int unsigned CLK_F  = 32,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned GAP_MS = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_period,
    input  logic [15:0]       wr_dur,
    input  logic [ADDR_W:0]   length,
    input  logic              start,
    input  logic              stop,
`ifdef TUNE_SEQUENCER_LOOP_EN
    input  logic              loop,
`endif
    output logic [31:0]       period,
    output logic              tone_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_idx
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned TICK  = CLK_F * 1000;
    localparam logic [ADDR_W-1:0] IDX_ONE = 1;
    localparam logic [ADDR_W:0]   LEN_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       per_mem [DEPTH];
    logic [15:0]       dur_mem [DEPTH];

    logic [31:0]       presc_q, presc_d;
    logic [15:0]       ms_q, ms_d;
    logic [31:0]       period_q, period_d;
    logic              tone_en_q, tone_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              tick;
    logic              advance;
    logic              is_last;

    // Table has no reset; contents are undefined until written.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            per_mem[wr_addr] <= wr_period;
            dur_mem[wr_addr] <= wr_dur;
        end
    end

    assign tick    = (presc_q == TICK - 1);
    assign is_last = (({1'b0, idx_q} + LEN_ONE) == len_q);

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        ms_d     = ms_q;
        idx_d    = idx_q;
        len_d    = len_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        presc_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                        len_d   = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                period_d = per_mem[idx_q];
                ms_d     = dur_mem[idx_q];
                if (dur_mem[idx_q] == '0) begin
                    advance = 1'b1;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (ms_q <= 16'd1) begin
                        if (GAP_MS != 0) begin
                            state_d = S_GAP;
                            ms_d    = 16'(GAP_MS);
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        ms_d = ms_q - 16'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (ms_q <= 16'd1) begin
                        advance = 1'b1;
                    end else begin
                        ms_d = ms_q - 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (is_last) begin
`ifdef TUNE_SEQUENCER_LOOP_EN
                if (loop) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`else
                state_d = S_IDLE;
                done_d  = 1'b1;
`endif
            end else begin
                state_d = S_LOAD;
                idx_d   = idx_q + IDX_ONE;
            end
        end

        // Abort overrides everything above, including a pending load or done pulse.
        if (stop) begin
            state_d  = S_IDLE;
            period_d = period_q;
            idx_d    = idx_q;
            done_d   = 1'b0;
        end

        if ((state_q == S_PLAY || state_q == S_GAP) && state_d == state_q) begin
            presc_d = tick ? '0 : presc_q + 32'd1;
        end

        busy_d    = (state_d != S_IDLE);
        tone_en_d = (state_d == S_PLAY) && (period_d != '0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            ms_q      <= '0;
            period_q  <= '0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ms_q      <= ms_d;
            period_q  <= period_d;
            tone_en_q <= tone_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
        end
    end

    assign period   = period_q;
    assign tone_en  = tone_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = idx_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Bench for tune_sequencer: per-cycle comparison against a timeline built from the playback rules.
module tb_tune_sequencer;

    localparam int unsigned CLK_F  = 1;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned GAP_MS = 2;
    localparam int          MS     = 1000;

    logic        CLK;
    logic        RST_N;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_period;
    logic [15:0] wr_dur;
    logic [3:0]  length;
    logic        start;
    logic        stop;
`ifdef TUNE_SEQUENCER_LOOP_EN
    logic        loop;
`endif
    logic [31:0] period;
    logic        tone_en;
    logic        busy;
    logic        done;
    logic [2:0]  note_idx;

    int checks;
    int errors;

    logic [31:0] mp [8];
    int          md [8];
    logic [31:0] m_period;
    logic [2:0]  m_idx;
    logic [37:0] exp_q [$];
    logic [37:0] obs;

    assign obs = {busy, done, tone_en, note_idx, period};

    tune_sequencer #(
        .CLK_F (CLK_F),
        .ADDR_W(ADDR_W),
        .GAP_MS(GAP_MS)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_period(wr_period),
        .wr_dur   (wr_dur),
        .length   (length),
        .start    (start),
        .stop     (stop),
`ifdef TUNE_SEQUENCER_LOOP_EN
        .loop     (loop),
`endif
        .period   (period),
        .tone_en  (tone_en),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [37:0] pk(input logic b, input logic d, input logic t,
                                       input logic [2:0] i, input logic [31:0] p);
        return {b, d, t, i, p};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected per-cycle outputs from the cycle after start is sampled:
    // one load cycle per entry, dur ms audible, GAP_MS ms silent, then a done cycle.
    function automatic void build(input int n, input int passes);
        exp_q.delete();
        for (int pass = 0; pass < passes; pass++) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 3'(i), m_period));
                m_period = mp[i];
                if (md[i] != 0) begin
                    repeat (md[i] * MS) exp_q.push_back(pk(1'b1, 1'b0, m_period != 0, 3'(i), m_period));
                    repeat (GAP_MS * MS) exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 3'(i), m_period));
                end
            end
        end
        if (n > 0) m_idx = 3'(n - 1);
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, m_idx, m_period));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, m_idx, m_period));
    endfunction

    task automatic wr(input int a, input logic [31:0] p, input int d);
        @(negedge CLK);
        wr_en     = 1'b1;
        wr_addr   = 3'(a);
        wr_period = p;
        wr_dur    = 16'(d);
        mp[a]     = p;
        md[a]     = d;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic run(input int n, input int passes, input int stop_at, input int loop_drop);
        build(n, passes);
        @(negedge CLK);
        length = 4'(n);
        start  = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge CLK);
            start = 1'b0;
            if (k == 0) length = 4'($urandom);
            check("cyc", 64'(obs), 64'(exp_q[k]));
            if (k == 50 && exp_q.size() > 60) start = 1'b1;
`ifdef TUNE_SEQUENCER_LOOP_EN
            if (k == loop_drop) loop = 1'b0;
`endif
            if (stop_at > 0 && k + 1 == stop_at) begin
                m_period = exp_q[k][31:0];
                m_idx    = exp_q[k][34:32];
                stop = 1'b1;
                @(negedge CLK);
                stop = 1'b0;
                repeat (3) begin
                    check("stop", 64'(obs), 64'(pk(1'b0, 1'b0, 1'b0, m_idx, m_period)));
                    @(negedge CLK);
                end
                return;
            end
        end
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        RST_N     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_period = '0;
        wr_dur    = '0;
        length    = '0;
        start     = 1'b0;
        stop      = 1'b0;
`ifdef TUNE_SEQUENCER_LOOP_EN
        loop      = 1'b0;
`endif
        m_period  = '0;
        m_idx     = '0;
        #3;
        check("reset", 64'(obs), 64'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Three-note tune with a rest in the middle
        wr(0, 32'd2272, 3);
        wr(1, 32'd0, 2);
        wr(2, 32'd1136, 1);
        run(3, 1, 0, -1);

        // Zero-duration entry is skipped outright
        wr(1, 32'd0, 0);
        run(3, 1, 0, -1);

        // Abort mid-note, then replay from entry 0 and abort again
        wr(1, 32'd0, 2);
        run(3, 1, 501, -1);
        run(3, 1, 1500, -1);

        // Simultaneous start and stop in idle: nothing starts
        @(negedge CLK);
        length = 4'd3;
        start  = 1'b1;
        stop   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        stop  = 1'b0;
        check("stop_start", 64'(obs), 64'(pk(1'b0, 1'b0, 1'b0, m_idx, m_period)));

        // Empty sequence: immediate done
        run(0, 1, 0, -1);

        // Asynchronous reset while a note is sounding
        build(3, 1);
        @(negedge CLK);
        length = 4'd3;
        start  = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(negedge CLK);
            start = 1'b0;
            check("cyc", 64'(obs), 64'(exp_q[k]));
        end
        #2 RST_N = 1'b0;
        #1 check("rst_async", 64'(obs), 64'd0);
        repeat (3) @(negedge CLK);
        check("rst_hold", 64'(obs), 64'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_idle", 64'(obs), 64'd0);
        m_period = '0;
        m_idx    = '0;

        // Random tables
        for (int r = 0; r < 2; r++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++)
                wr(i, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, int'($urandom_range(0, 2)));
            run(n, 1, 0, -1);
        end

`ifdef TUNE_SEQUENCER_LOOP_EN
        // Loop twice, dropping loop during the second pass
        wr(0, 32'd500, 1);
        wr(1, 32'd700, 1);
        loop = 1'b1;
        run(2, 2, 0, 2 * (1 + MS + GAP_MS * MS) + 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
